// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl
//   Captures camera frames from an 8-bit RGB444 byte bus (two bytes per pixel)
//   into a frame buffer. Arms on request, aligns to the next frame start,
//   packs byte pairs into 12-bit pixels and writes them line by line. Also
//   reports frame completion, line/frame geometry errors and a frame count.
//
// Ports
//   cam_clk      pixel-byte clock, rising edge
//   rstn         asynchronous active-low reset
//   cam_vsync    camera VSYNC, high = vertical blanking
//   cam_href     camera HREF, high = valid bytes
//   cam_data     camera byte bus
//   arm          pulse: request capture (ignored while busy)
//   continuous   1 = capture frames until stop, 0 = single frame
//   stop         pulse: end (continuous) or abort (single) capture
//   err_clr      pulse: clear sticky error flags
//   wr_en        frame-buffer write strobe
//   wr_addr      frame-buffer address
//   wr_data      pixel {R[3:0],G[3:0],B[3:0]}
//   busy         high in any state except IDLE
//   frame_done   one-cycle pulse per completed frame
//   frame_cnt    completed frames since reset (wraps)
//   last_lines   HREF lines counted in the last completed frame
//   err_line     sticky: line ended with wrong pixel count or half a pixel
//   err_frame    sticky: frame ended with wrong line count
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | not capturing, waiting for arm
// WAIT_VS    | armed, waiting for VSYNC high (blanking)
// WAIT_START | in blanking, waiting for VSYNC falling edge
// CAPTURE    | capturing lines until VSYNC rises again

module cam_capture_ctrl #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int ADDR_W  = 19
) (
    input  logic              cam_clk,
    input  logic              rstn,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              arm,
    input  logic              continuous,
    input  logic              stop,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic [9:0]        last_lines,
    output logic              err_line,
    output logic              err_frame
);

    // Pixel counter keeps counting past H_PIX (clipped pixels) and saturates.
    localparam int                PW        = $clog2(H_PIX + 1) + 1;
    localparam logic [PW-1:0]     H_PIX_P   = PW'(H_PIX);
    localparam logic [PW-1:0]     PIX_MAX   = '1;
    localparam logic [9:0]        V_LINES_L = 10'(V_LINES);
    localparam logic [9:0]        LINE_MAX  = 10'h3FF;
    localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_PIX);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VS    = 2'd1,
        WAIT_START = 2'd2,
        CAPTURE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              vs_q, vs_q2;
    logic              hr_q, hr_q2;
    logic [7:0]        d_q;
    logic              vs_rise, vs_fall, hr_fall;

    logic              phase;
    logic [3:0]        r_nib;
    logic [PW-1:0]     pix_cnt;
    logic [9:0]        line_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              stop_seen;

    logic              take_byte;
    logic              line_end;
    logic              frame_end;
    logic              start_frame;
    logic [9:0]        line_cnt_inc;
    logic [9:0]        line_cnt_end;
    logic              pix_ok;
    logic              line_bad;

    always_ff @(posedge cam_clk or negedge rstn) begin
        if (!rstn) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            hr_q  <= 1'b0;
            hr_q2 <= 1'b0;
            d_q   <= 8'h00;
        end else begin
            vs_q  <= cam_vsync;
            vs_q2 <= vs_q;
            hr_q  <= cam_href;
            hr_q2 <= hr_q;
            d_q   <= cam_data;
        end
    end

    assign vs_rise = vs_q & ~vs_q2;
    assign vs_fall = ~vs_q & vs_q2;
    assign hr_fall = ~hr_q & hr_q2;

    always_ff @(posedge cam_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        take_byte   = 1'b0;
        line_end    = 1'b0;
        frame_end   = 1'b0;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                if (arm) state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (stop)      state_nxt = IDLE;
                else if (vs_q) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (vs_fall) begin
                    state_nxt   = CAPTURE;
                    start_frame = 1'b1;
                end
            end
            CAPTURE: begin
                // A single-frame stop aborts at once: nothing else in this
                // cycle takes effect, which also drops any pending write.
                if (stop && !continuous) begin
                    state_nxt = IDLE;
                end else begin
                    // A line still open at frame end is closed in the same
                    // cycle; its last byte is not taken.
                    take_byte = hr_q & ~vs_rise;
                    line_end  = hr_fall | (vs_rise & hr_q);
                    if (vs_rise) begin
                        frame_end = 1'b1;
                        if (continuous && !stop_seen && !stop) state_nxt = WAIT_START;
                        else                                    state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign line_cnt_inc = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + 10'd1;
    assign line_cnt_end = line_end ? line_cnt_inc : line_cnt;
    assign pix_ok       = (pix_cnt < H_PIX_P) && (line_cnt < V_LINES_L);
    assign line_bad     = (pix_cnt != H_PIX_P) || phase;

    always_ff @(posedge cam_clk or negedge rstn) begin
        if (!rstn) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 12'h000;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
            last_lines <= 10'd0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
            phase      <= 1'b0;
            r_nib      <= 4'h0;
            pix_cnt    <= '0;
            line_cnt   <= 10'd0;
            line_base  <= '0;
            stop_seen  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (start_frame) begin
                phase     <= 1'b0;
                pix_cnt   <= '0;
                line_cnt  <= 10'd0;
                line_base <= '0;
            end

            if (take_byte) begin
                if (!phase) begin
                    r_nib <= d_q[3:0];
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 1'b1;
                    if (pix_ok) begin
                        wr_en   <= 1'b1;
                        wr_addr <= line_base + ADDR_W'(pix_cnt);
                        wr_data <= {r_nib, d_q};
                    end
                end
            end

            if (line_end) begin
                line_cnt <= line_cnt_inc;
                if (line_cnt < V_LINES_L) line_base <= line_base + H_STEP;
                pix_cnt  <= '0;
                phase    <= 1'b0;
            end

            if (frame_end) begin
                last_lines <= line_cnt_end;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
            end

            // Setting wins over a simultaneous clear.
            err_line  <= (err_line & ~err_clr) | (line_end & line_bad);
            err_frame <= (err_frame & ~err_clr) | (frame_end & (line_cnt_end != V_LINES_L));

            if (state == IDLE)                 stop_seen <= 1'b0;
            else if (state == CAPTURE && stop) stop_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with a reduced frame geometry
// (4 pixels x 5 lines) so that every scenario runs in a few thousand cycles.

module tb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 5;
    localparam int AW = 5;

    logic          cam_clk;
    logic          rstn;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          arm;
    logic          continuous;
    logic          stop;
    logic          err_clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [9:0]    last_lines;
    logic          err_line;
    logic          err_frame;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] wq_addr[$];
    logic [11:0]   wq_data[$];
    int            done_cnt = 0;
    int            max_addr = 0;
    logic          mon_clr  = 1'b0;

    cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .cam_clk    (cam_clk),
        .rstn       (rstn),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .arm        (arm),
        .continuous (continuous),
        .stop       (stop),
        .err_clr    (err_clr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .last_lines (last_lines),
        .err_line   (err_line),
        .err_frame  (err_frame)
    );

    initial cam_clk = 1'b0;
    always #5 cam_clk = ~cam_clk;

    // Write / frame_done recorder, sampled on the falling edge.
    always @(negedge cam_clk) begin
        if (mon_clr) begin
            wq_addr.delete();
            wq_data.delete();
            done_cnt = 0;
            max_addr = 0;
        end else begin
            if (wr_en === 1'b1) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
                if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge cam_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge cam_clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Blanking interval: VSYNC high for a few cycles, then low before lines.
    task automatic frame_gap();
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    // One HREF line; pulse_sel 1 = arm, 2 = stop, asserted with byte pulse_at.
    task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                             input int pulse_at, input int pulse_sel);
        for (int i = 0; i < nbytes; i++) begin
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? b0 : b1;
            arm      = (pulse_sel == 1) && (i == pulse_at);
            stop     = (pulse_sel == 2) && (i == pulse_at);
            tick();
        end
        arm      = 1'b0;
        stop     = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic send_lines(input int n, input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
        for (int l = 0; l < n; l++) send_line(nbytes, b0, b1, 0, 0);
    endtask

    initial begin
        rstn       = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b0;
        cam_data   = 8'h00;
        arm        = 1'b0;
        continuous = 1'b0;
        stop       = 1'b0;
        err_clr    = 1'b0;
        repeat (3) tick();

        check("rst_wr_en",      32'(wr_en),      0);
        check("rst_wr_addr",    32'(wr_addr),    0);
        check("rst_wr_data",    32'(wr_data),    0);
        check("rst_busy",       32'(busy),       0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_cnt",  32'(frame_cnt),  0);
        check("rst_last_lines", 32'(last_lines), 0);
        check("rst_err_line",   32'(err_line),   0);
        check("rst_err_frame",  32'(err_frame),  0);

        rstn = 1'b1;
        repeat (2) tick();

        // Single frame
        clear_mon();
        pulse_arm();
        check("single_busy_armed", 32'(busy), 1);
        frame_gap();
        send_lines(V, 2 * H, 8'h0A, 8'h5C);
        frame_gap();
        check("single_writes",     32'(wq_addr.size()), 20);
        check("single_first_addr", 32'(wq_addr[0]),     0);
        check("single_first_data", 32'(wq_data[0]),     32'h0A5C);
        check("single_last_addr",  32'(wq_addr[$]),     19);
        check("single_done_cnt",   32'(done_cnt),       1);
        check("single_frame_cnt",  32'(frame_cnt),      1);
        check("single_last_lines", 32'(last_lines),     5);
        check("single_err_line",   32'(err_line),       0);
        check("single_err_frame",  32'(err_frame),      0);
        check("single_busy_end",   32'(busy),           0);

        // Arm in the middle of an active frame
        clear_mon();
        send_line(2 * H, 8'h0A, 8'h5C, 2, 1);
        send_lines(1, 2 * H, 8'h0A, 8'h5C);
        check("midarm_no_writes", 32'(wq_addr.size()), 0);
        check("midarm_busy",      32'(busy),           1);
        frame_gap();
        send_lines(V, 2 * H, 8'h01, 8'h23);
        frame_gap();
        check("midarm_writes",     32'(wq_addr.size()), 20);
        check("midarm_first_addr", 32'(wq_addr[0]),     0);
        check("midarm_first_data", 32'(wq_data[0]),     32'h0123);
        check("midarm_last_addr",  32'(wq_addr[$]),     19);
        check("midarm_frame_cnt",  32'(frame_cnt),      2);

        // Short / odd line 3
        clear_mon();
        pulse_arm();
        frame_gap();
        send_lines(3, 2 * H, 8'h0A, 8'h5C);
        send_line(2 * H - 1, 8'h0A, 8'h5C, 0, 0);
        send_lines(1, 2 * H, 8'h0A, 8'h5C);
        frame_gap();
        check("short_writes",      32'(wq_addr.size()), 19);
        check("short_line3_last",  32'(wq_addr[14]),    14);
        check("short_line4_first", 32'(wq_addr[15]),    16);
        check("short_err_line",    32'(err_line),       1);
        check("short_err_frame",   32'(err_frame),      0);
        check("short_last_lines",  32'(last_lines),     5);
        check("short_frame_cnt",   32'(frame_cnt),      3);
        pulse_err_clr();
        tick();
        check("short_err_clr",     32'(err_line),       0);

        // Oversized frame: 7 lines of 5 pixels
        clear_mon();
        pulse_arm();
        frame_gap();
        send_lines(V + 2, 2 * H + 2, 8'h0A, 8'h5C);
        frame_gap();
        check("over_writes",     32'(wq_addr.size()), 20);
        check("over_max_addr",   32'(max_addr),       19);
        check("over_last_lines", 32'(last_lines),     7);
        check("over_err_frame",  32'(err_frame),      1);
        check("over_err_line",   32'(err_line),       1);
        check("over_frame_cnt",  32'(frame_cnt),      4);

        // Continuous capture, then stop during frame 4
        clear_mon();
        continuous = 1'b1;
        pulse_arm();
        for (int f = 0; f < 3; f++) begin
            frame_gap();
            send_lines(V, 2 * H, 8'h0A, 8'h5C);
        end
        frame_gap();
        check("cont_frame_cnt3", 32'(frame_cnt), 7);
        check("cont_done_cnt3",  32'(done_cnt),  3);
        check("cont_busy3",      32'(busy),      1);
        send_lines(1, 2 * H, 8'h0A, 8'h5C);
        send_line(2 * H, 8'h0A, 8'h5C, 2, 2);
        send_lines(V - 2, 2 * H, 8'h0A, 8'h5C);
        check("cont_busy_after_stop", 32'(busy), 1);
        frame_gap();
        check("cont_frame_cnt4", 32'(frame_cnt),      8);
        check("cont_done_cnt4",  32'(done_cnt),       4);
        check("cont_busy4",      32'(busy),           0);
        check("cont_writes",     32'(wq_addr.size()), 80);
        continuous = 1'b0;

        // Abort a single-frame capture on line 2
        clear_mon();
        pulse_arm();
        frame_gap();
        send_lines(2, 2 * H, 8'h0A, 8'h5C);
        for (int i = 0; i < 2 * H; i++) begin
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? 8'h0A : 8'h5C;
            stop     = (i == 4);
            tick();
            if (i == 4) check("abort_busy_now", 32'(busy), 0);
        end
        stop     = 1'b0;
        cam_href = 1'b0;
        repeat (3) tick();
        send_lines(2, 2 * H, 8'h0A, 8'h5C);
        frame_gap();
        check("abort_writes",    32'(wq_addr.size()), 9);
        check("abort_done_cnt",  32'(done_cnt),       0);
        check("abort_frame_cnt", 32'(frame_cnt),      8);
        check("abort_busy",      32'(busy),           0);

        // Asynchronous reset in the middle of a frame
        clear_mon();
        pulse_arm();
        frame_gap();
        send_lines(1, 2 * H, 8'h0A, 8'h5C);
        cam_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cam_data = (i % 2 == 0) ? 8'h0A : 8'h5C;
            tick();
        end
        rstn = 1'b0;
        #2;
        check("arst_wr_en",      32'(wr_en),      0);
        check("arst_wr_addr",    32'(wr_addr),    0);
        check("arst_wr_data",    32'(wr_data),    0);
        check("arst_busy",       32'(busy),       0);
        check("arst_frame_done", 32'(frame_done), 0);
        check("arst_frame_cnt",  32'(frame_cnt),  0);
        check("arst_last_lines", 32'(last_lines), 0);
        check("arst_err_line",   32'(err_line),   0);
        check("arst_err_frame",  32'(err_frame),  0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        cam_href = 1'b0;
        repeat (3) tick();
        send_lines(2, 2 * H, 8'h0A, 8'h5C);
        frame_gap();
        check("arst_after_frame_cnt", 32'(frame_cnt), 0);
        check("arst_after_done_cnt",  32'(done_cnt),  0);
        check("arst_after_busy",      32'(busy),      0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences capture of one or more camera frames from the OV-style 8-bit RGB444 pixel bus into the 640x480x12 frame buffer.
- Arms on a software or button request and aligns to the start of a frame.
- Assembles byte pairs into 12-bit pixels and generates the frame-buffer write strobe, address and data.
- Reports frame completion, line/frame geometry errors and status to the register block.

Parameters:
- H_PIX, 640, pixels per line.
- V_LINES, 480, lines per frame.
- ADDR_W, 19, frame-buffer address width; H_PIX*V_LINES must be <= 2^ADDR_W.

Ports:
- cam_clk  in  1  pixel-byte clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- cam_vsync  in  1  camera VSYNC; high = vertical blanking.
- cam_href  in  1  camera HREF; high = valid bytes.
- cam_data  in  8  camera byte bus.
- arm  in  1  single-cycle pulse; request capture.
- continuous  in  1  1 = keep capturing frames until stop; 0 = single frame.
- stop  in  1  single-cycle pulse; abort or end capture.
- err_clr  in  1  single-cycle pulse; clear sticky errors.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  frame-buffer address.
- wr_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at a completed frame.
- frame_cnt  out  16  completed frames since reset; wraps.
- last_lines  out  10  HREF lines counted in the last completed frame.
- err_line  out  1  sticky: a line ended with pixel count != H_PIX or with an odd byte count.
- err_frame  out  1  sticky: a frame ended with line count != V_LINES.

Behaviour:
- **Input registering:** cam_vsync, cam_href and cam_data are registered once (vs_q, hr_q, d_q). Edges are detected from the registered signal against a second flop. All internal decisions use the registered values.
- **Reset:** state = IDLE; wr_en = 0, wr_addr = 0, wr_data = 0; busy = 0, frame_done = 0, frame_cnt = 0, last_lines = 0; err_line = 0, err_frame = 0; byte phase, pixel count, line count and line base all 0.
- **IDLE:**
  - arm -> WAIT_VS.
  - stop in IDLE has no effect.
- **WAIT_VS:** wait for vs_q high. Entering while vs_q is already high is allowed. -> WAIT_START.
- **WAIT_START:** on vs_q falling edge -> CAPTURE. Clear line count, line base, pixel count and byte phase.
- **CAPTURE:**
  - While hr_q = 1, the byte phase toggles on every byte:
    - Phase 0 byte: its low nibble is latched as R.
    - Phase 1 byte: forms the pixel {R, d_q[7:4], d_q[3:0]}.
  - wr_en pulses for one cycle on the cycle after the phase-1 byte is registered. Latency is 2 cam_clk from the phase-1 byte at the port to wr_en = 1.
  - wr_addr = line base + pixel count.
  - A write occurs only if pixel count < H_PIX and line count < V_LINES. Excess pixels and lines are dropped (clipped), but still counted.
  - On hr_q falling edge:
    - If pixel count != H_PIX or byte phase = 1, set err_line.
    - Increment line count (saturates at 1023). Add H_PIX to line base (line base only advances while line count < V_LINES).
    - Reset pixel count and byte phase. A half pixel is discarded, never written.
  - On vs_q rising edge:
    - last_lines = line count.
    - Set err_frame if line count != V_LINES.
    - frame_done = 1 for one cycle; frame_cnt + 1.
    - Then go to WAIT_START if continuous = 1 and no stop has been seen; otherwise go to IDLE.
  - An HREF line still active when vs_q rises is closed first with the normal end-of-line rules, in the same cycle.
- **stop:**
  - In WAIT_VS or WAIT_START: -> IDLE.
  - In CAPTURE with continuous = 1: the current frame completes normally, then -> IDLE.
  - In CAPTURE with continuous = 0: abort immediately -> IDLE. No frame_done; frame_cnt unchanged; any pending wr_en is suppressed.
- **Other inputs and precedence:**
  - arm while busy is ignored.
  - err_clr clears both sticky flags. A simultaneous set wins over the clear.
  - continuous is sampled at each end of frame.
- **wr_data:** holds the last written pixel between writes.
- **Asynchronous reset mid-frame:** returns everything to its reset values. No partial frame_done.

Test Plan:
- **Single frame:** arm, continuous = 0; bench drives VSYNC high 10 cycles, then low, 480 lines of 1280 bytes with byte pair (0x0A,0x5C) -> 307200 wr_en pulses; first write wr_addr = 0, wr_data = 0xA5C; last write wr_addr = 307199; frame_done once; frame_cnt = 1; last_lines = 480; no errors; back to IDLE, busy = 0.
- **Mid-frame arm:** arm while VSYNC low with HREF active -> no writes until after the next VSYNC high->low; the capture then starts at wr_addr = 0.
- **Short and odd lines:** line 3 has 1279 bytes -> 639 writes for that line and err_line = 1; line 4 starts at wr_addr = 4*640 = 2560. err_clr with no new error -> err_line = 0.
- **Oversized frame:** 482 lines of 1300 bytes -> writes clipped to pixels 0..639 and lines 0..479, no address above 307199; last_lines = 482; err_frame = 1; err_line = 1.
- **Continuous then stop:** continuous = 1; run 3 frames -> frame_cnt = 3, one frame_done per frame. stop mid-frame 4 -> frame 4 completes, frame_cnt = 4, then IDLE.
- **Abort:** continuous = 0; stop after 100 lines -> IDLE within 1 cycle, wr_en stays 0 afterwards, no frame_done. rstn pulse mid-frame -> all outputs at reset values.
